cape_gpio_pads: RTL and testbench



---
 rtl/cape_gpio_pads.sv | 122 ++++++++++++
 tb/tb_cape_gpio_pads.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cape_gpio_pads.sv
// Cape header pad wrapper: per-pin BIBUF output path plus synchronised, debounced input
// path with edge capture into sticky IRQ status. Optional open-drain mode: CAPE_GPIO_OPEN_DRAIN_EN.
module cape_gpio_pads #(
    parameter int NUM_PINS    = 11,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic [NUM_PINS-1:0]   GPIO_OUT,
    input  logic [NUM_PINS-1:0]   GPIO_OE,
    input  logic [NUM_PINS-1:0]   GPIO_OD,
    input  logic [DEBOUNCE_W-1:0] DEBOUNCE_TICKS,
    input  logic [NUM_PINS-1:0]   RISE_EN,
    input  logic [NUM_PINS-1:0]   FALL_EN,
    input  logic [NUM_PINS-1:0]   IRQ_CLEAR,
    output logic [NUM_PINS-1:0]   GPIO_IN,
    output logic [NUM_PINS-1:0]   IRQ_STATUS,
    output logic                  IRQ,
    inout  wire  [NUM_PINS-1:0]   PADS
);

    localparam int IW = $clog2(SYNC_STAGES + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         init_cnt_q, init_cnt_d;
    logic [NUM_PINS-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0]   stable_q, stable_d;
    logic [DEBOUNCE_W-1:0] cnt_q [NUM_PINS];
    logic [DEBOUNCE_W-1:0] cnt_d [NUM_PINS];
    logic [NUM_PINS-1:0]   status_q, status_d;
    logic                  irq_q;
    logic [NUM_PINS-1:0]   rise, fall;
    logic [NUM_PINS-1:0]   pad_d, pad_e, pad_y, s;

`ifdef CAPE_GPIO_OPEN_DRAIN_EN
    // Open-drain pins never drive high: a 1 releases the line.
    assign pad_d = GPIO_OUT & ~GPIO_OD;
    assign pad_e = GPIO_OE & ~(GPIO_OD & GPIO_OUT);
`else
    logic unused_od;
    assign unused_od = ^GPIO_OD;
    assign pad_d     = GPIO_OUT;
    assign pad_e     = GPIO_OE;
`endif

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pad
        assign PADS[g] = pad_e[g] ? pad_d[g] : 1'bz;
    end
    assign pad_y = PADS;
    assign s     = sync_q[SYNC_STAGES-1];

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= pad_y;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            stable_q   <= '0;
            status_q   <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            stable_q   <= stable_d;
            status_q   <= status_d;
            irq_q      <= |status_q;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // INIT copies the synchronised level straight into stable so post-reset pin
    // levels never look like edges; RUN debounces each pin independently.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        stable_d   = stable_q;
        rise       = '0;
        fall       = '0;
        for (int i = 0; i < NUM_PINS; i++) cnt_d[i] = cnt_q[i];
        case (state_q)
            ST_INIT: begin
                stable_d = s;
                for (int i = 0; i < NUM_PINS; i++) cnt_d[i] = '0;
                if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
                else init_cnt_d = init_cnt_q + 1'b1;
            end
            default: begin
                for (int i = 0; i < NUM_PINS; i++) begin
                    if (s[i] == stable_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] >= DEBOUNCE_TICKS) begin
                        stable_d[i] = s[i];
                        cnt_d[i]    = '0;
                        rise[i]     = s[i];
                        fall[i]     = ~s[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        endcase
        // A new capture outranks a simultaneous clear.
        status_d = (status_q & ~IRQ_CLEAR) | (rise & RISE_EN) | (fall & FALL_EN);
    end

    assign GPIO_IN    = stable_q;
    assign IRQ_STATUS = status_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_cape_gpio_pads.sv
// Directed bench for cape_gpio_pads (NUM_PINS=11, SYNC_STAGES=2, DEBOUNCE_W=8).
module tb_cape_gpio_pads;

    localparam int N = 11;

    logic         PCLK = 1'b0;
    logic         PRESETN = 1'b0;
    logic [N-1:0] GPIO_OUT = '0, GPIO_OE = '0, GPIO_OD = '0;
    logic [7:0]   DEBOUNCE_TICKS = 8'd3;
    logic [N-1:0] RISE_EN = '0, FALL_EN = '0, IRQ_CLEAR = '0;
    logic [N-1:0] GPIO_IN, IRQ_STATUS;
    logic         IRQ;
    wire  [N-1:0] pads;
    logic [N-1:0] ext_en = '0, ext_val = '0;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < N; g++) begin : g_ext
        assign pads[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    cape_gpio_pads #(.NUM_PINS(N), .SYNC_STAGES(2), .DEBOUNCE_W(8)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .GPIO_OD(GPIO_OD),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .RISE_EN(RISE_EN), .FALL_EN(FALL_EN), .IRQ_CLEAR(IRQ_CLEAR),
        .GPIO_IN(GPIO_IN), .IRQ_STATUS(IRQ_STATUS), .IRQ(IRQ),
        .PADS(pads)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every pad held high.
        ext_en  = '1;
        ext_val = '1;
        RISE_EN = '1;
        tick(2);
        check_eq("rst_gpio_in", 32'(GPIO_IN), 32'h0);
        check_eq("rst_status",  32'(IRQ_STATUS), 32'h0);
        check_eq("rst_irq",     32'(IRQ), 32'h0);
        PRESETN = 1'b1;
        tick(2);
        check_eq("init_gpio_in_2", 32'(GPIO_IN), 32'h0);
        tick(1);
        check_eq("init_gpio_in_3", 32'(GPIO_IN), 32'h7FF);
        tick(5);
        check_eq("init_no_edge_status", 32'(IRQ_STATUS), 32'h0);
        check_eq("init_no_edge_irq",    32'(IRQ), 32'h0);

        // Restart with all pads low.
        ext_val = '0;
        PRESETN = 1'b0;
        tick(2);
        PRESETN = 1'b1;
        tick(8);
        check_eq("rst2_gpio_in", 32'(GPIO_IN), 32'h0);
        check_eq("rst2_status",  32'(IRQ_STATUS), 32'h0);

        // Pin 0 rising edge, TICKS=3 -> accepted 6 cycles after pad change.
        ext_val[0] = 1'b1;
        tick(5);
        check_eq("p0_lat5", 32'(GPIO_IN), 32'h000);
        tick(1);
        check_eq("p0_lat6",    32'(GPIO_IN), 32'h001);
        check_eq("p0_status",  32'(IRQ_STATUS), 32'h001);
        check_eq("p0_irq_lag", 32'(IRQ), 32'h0);
        tick(1);
        check_eq("p0_irq", 32'(IRQ), 32'h1);
        IRQ_CLEAR = 11'h001;
        tick(1);
        IRQ_CLEAR = '0;
        check_eq("p0_clr_status", 32'(IRQ_STATUS), 32'h0);
        check_eq("p0_clr_irq_lag", 32'(IRQ), 32'h1);
        tick(1);
        check_eq("p0_clr_irq", 32'(IRQ), 32'h0);

        // Pin 1: 3-cycle glitch rejected.
        ext_val[1] = 1'b1;
        tick(3);
        ext_val[1] = 1'b0;
        tick(10);
        check_eq("p1_glitch_in",     32'(GPIO_IN), 32'h001);
        check_eq("p1_glitch_status", 32'(IRQ_STATUS), 32'h0);

        // Pin 1: 4-cycle pulse accepted as rise then fall; fall not enabled.
        ext_val[1] = 1'b1;
        tick(4);
        ext_val[1] = 1'b0;
        tick(1);
        check_eq("p1_pulse_5", 32'(GPIO_IN), 32'h001);
        tick(1);
        check_eq("p1_pulse_6",  32'(GPIO_IN), 32'h003);
        check_eq("p1_rise_set", 32'(IRQ_STATUS), 32'h002);
        tick(3);
        check_eq("p1_pulse_9", 32'(GPIO_IN), 32'h003);
        tick(1);
        check_eq("p1_pulse_10",   32'(GPIO_IN), 32'h001);
        check_eq("p1_fall_gated", 32'(IRQ_STATUS), 32'h002);
        IRQ_CLEAR = 11'h002;
        tick(2);
        IRQ_CLEAR = '0;

        // Pin 2: falling edge coinciding with clear -> set wins.
        ext_val[2] = 1'b1;
        tick(8);
        check_eq("p2_high_in",     32'(GPIO_IN), 32'h005);
        check_eq("p2_rise_status", 32'(IRQ_STATUS), 32'h004);
        IRQ_CLEAR = 11'h004;
        FALL_EN   = 11'h004;
        tick(1);
        IRQ_CLEAR = '0;
        check_eq("p2_pre_clear", 32'(IRQ_STATUS), 32'h0);
        ext_val[2] = 1'b0;
        tick(5);
        IRQ_CLEAR = 11'h004;
        tick(1);
        IRQ_CLEAR = '0;
        FALL_EN   = '0;
        check_eq("p2_fall_in",  32'(GPIO_IN), 32'h001);
        check_eq("p2_set_wins", 32'(IRQ_STATUS), 32'h004);
        tick(1);
        check_eq("p2_en_off_keeps", 32'(IRQ_STATUS), 32'h004);
        IRQ_CLEAR = 11'h004;
        tick(1);
        IRQ_CLEAR = '0;
        check_eq("p2_cleared",     32'(IRQ_STATUS), 32'h0);
        check_eq("p2_irq_lag",     32'(IRQ), 32'h1);
        tick(1);
        check_eq("p2_irq_dropped", 32'(IRQ), 32'h0);

        // Pin 4: TICKS=0 gives pure synchroniser latency + 1.
        DEBOUNCE_TICKS = 8'd0;
        ext_val[4] = 1'b1;
        tick(2);
        check_eq("p4_t0_lat2", 32'(GPIO_IN), 32'h001);
        tick(1);
        check_eq("p4_t0_lat3",  32'(GPIO_IN), 32'h011);
        check_eq("p4_t0_status", 32'(IRQ_STATUS), 32'h010);
        DEBOUNCE_TICKS = 8'd3;
        IRQ_CLEAR = '1;
        tick(1);
        IRQ_CLEAR = '0;

        // Reset in the middle of a debounce count on pin 5.
        ext_val[5] = 1'b1;
        tick(3);
        PRESETN = 1'b0;
        #1;
        check_eq("mid_rst_in",  32'(GPIO_IN), 32'h0);
        check_eq("mid_rst_irq", 32'(IRQ), 32'h0);
        tick(1);
        PRESETN = 1'b1;
        tick(3);
        check_eq("mid_rst_init_in", 32'(GPIO_IN), 32'h031);
        tick(8);
        check_eq("mid_rst_status", 32'(IRQ_STATUS), 32'h0);

        // Output drive and loopback.
        ext_en   = '0;
        GPIO_OE  = 11'h7FF;
        GPIO_OUT = 11'h555;
        #1;
        check_eq("drive_pads", 32'(pads), 32'h555);
        tick(8);
        check_eq("loop_in",     32'(GPIO_IN), 32'h555);
        check_eq("loop_status", 32'(IRQ_STATUS), 32'h544);
        GPIO_OE = '0;
        ext_en  = '1;
        ext_val = 11'h2AA;
        #1;
        check_eq("hiz_ext_pads", 32'(pads), 32'h2AA);
        tick(8);
        check_eq("hiz_ext_in", 32'(GPIO_IN), 32'h2AA);

        // Open-drain select on pin 3.
        ext_val  = '0;
        ext_en   = 11'h7F7;
        GPIO_OD  = 11'h008;
        GPIO_OE  = 11'h008;
        GPIO_OUT = 11'h008;
`ifdef CAPE_GPIO_OPEN_DRAIN_EN
        ext_en  = 11'h7FF;
        ext_val = 11'h008;
`endif
        #1;
        check_eq("od_out1_pad3", 32'(pads[3]), 32'h1);
`ifdef CAPE_GPIO_OPEN_DRAIN_EN
        ext_en  = 11'h7F7;
        ext_val = '0;
`endif
        GPIO_OUT = '0;
        #1;
        check_eq("od_out0_pad3", 32'(pads[3]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
